uart_byte_rx: RTL

Serial UART receiver that sits directly upstream of the frame FIFO/parser stage. It oversamples the asynchronous rxd line, deserializes 8N1 characters (LSB first) and presents each byte with a one-cycle strobe. The strobe and byte drive the parser's start/mosi inputs. Frame errors are flagged and the bad byte is dropped, so the parser never sees a corrupted byte.

---
 rtl/uart_byte_rx.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_byte_rx
//  Description : Oversampling 8N1 UART receiver. Synchronizes rxd, detects
//                the start edge, samples each bit at mid-period and presents
//                each good byte with a one-cycle data_valid strobe. A low
//                stop bit pulses frame_err, drops the byte and parks in BREAK
//                until the line returns high.
//                Optional macro UART_RX_PARITY_EN adds an even-parity bit
//                after the data bits and drives parity_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_byte_rx #(
    parameter int CLK_DIV     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int c_cnt_w = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_half_cnt = c_cnt_w'(CLK_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_rx_prev;
    logic [c_cnt_w-1:0]       r_cnt;
    logic [2:0]               r_bit_idx;
    logic [7:0]               r_shift;
    logic                     w_rx_s;

    assign w_rx_s = r_sync[SYNC_STAGES-1];

    // Synchronize rxd (flops preset to idle-high) and remember the previous rx_s for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], rxd};
            r_rx_prev <= w_rx_s;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
`else
    // Without the parity bit there is nothing to check
    assign parity_err = 1'b0;
`endif

    // Receive FSM; all outputs are registered, pulses default low every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (r_rx_prev && !w_rx_s) begin
                        r_state <= S_START;
                        busy    <= 1'b1;
                    end
                end

                // Re-check the start bit at its midpoint to reject glitches
                S_START: begin
                    if (r_cnt == c_half_cnt) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                        end else begin
                            r_state   <= S_DATA;
                            r_bit_idx <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // One full bit period after each mid-bit point lands on the next mid-bit
                S_DATA: begin
                    if (r_cnt == c_full_cnt) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                // Even parity: XOR of data and parity bit must be zero
                S_PARITY: begin
                    if (r_cnt == c_full_cnt) begin
                        r_cnt     <= '0;
                        r_par_bad <= ^{w_rx_s, r_shift};
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                // Return to IDLE at mid-stop so a back-to-back start edge is caught
                S_STOP: begin
                    if (r_cnt == c_full_cnt) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            data_out   <= r_shift;
                            data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= r_par_bad;
`endif
                            r_state    <= S_IDLE;
                            busy       <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                            r_state   <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                // A held-low line must not decode as a stream of 0x00 bytes
                S_BREAK: begin
                    r_cnt <= '0;
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
